cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: float and load results queue in private FIFOs, and one result per cycle is registered onto the bus.
// Latency: a result accepted at edge N broadcasts after edge N+1. The bus has no backpressure; x_ready drops only when the FIFO is full.
// Defining CDB_FIXED_PRIO_EN selects fixed float-first priority; the default build uses a round-robin arbiter.

module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushValid,
  output logic             pushReady,
  input  logic [WIDTH-1:0] pushData,
  input  logic             popEn,
  output logic             headValid,
  output logic [WIDTH-1:0] headData,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready comes from the registered count, so a full FIFO refuses a push even on an edge that pops.
  assign pushReady = (count != CW'(DEPTH));
  assign headValid = (count != '0);
  assign doPush    = pushValid && pushReady;
  assign doPop     = popEn && headValid;
  assign headData  = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
endmodule

module cdb_arbiter #(
  parameter int DEPTH = 2,
  parameter int W     = 16,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fu_valid,
  output logic                       fu_ready,
  input  logic [W-1:0]               fu_data,
  input  logic [TAG_W-1:0]           fu_src,
  input  logic [TAG_W-1:0]           fu_reg,
  input  logic                       fu_jeq,
  input  logic                       fu_taken,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [W-1:0]               ld_data,
  input  logic [TAG_W-1:0]           ld_src,
  input  logic [TAG_W-1:0]           ld_reg,
  output logic                       bus_valid,
  output logic [W-1:0]               bus_data,
  output logic [TAG_W-1:0]           bus_src,
  output logic [TAG_W-1:0]           bus_reg,
  output logic                       bus_jeq,
  output logic                       bus_taken,
  output logic                       bus_from,
  output logic [$clog2(DEPTH+1)-1:0] fu_count,
  output logic [$clog2(DEPTH+1)-1:0] ld_count
);
  typedef struct packed {
    logic [W-1:0]     data;
    logic [TAG_W-1:0] src;
    logic [TAG_W-1:0] dst;
    logic             jeq;
    logic             taken;
  } result_t;

  localparam int RW = $bits(result_t);

  result_t fuIn, ldIn, fuHead, ldHead, selHead;
  logic    fuHv, ldHv;
  logic    grantFu, grantLd;

  assign fuIn = '{data: fu_data, src: fu_src, dst: fu_reg, jeq: fu_jeq, taken: fu_jeq & fu_taken};
  assign ldIn = '{data: ld_data, src: ld_src, dst: ld_reg, jeq: 1'b0, taken: 1'b0};

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(RW)) fuFifo (
    .clk       (clk),
    .rst       (rst),
    .pushValid (fu_valid),
    .pushReady (fu_ready),
    .pushData  (fuIn),
    .popEn     (grantFu),
    .headValid (fuHv),
    .headData  (fuHead),
    .count     (fu_count)
  );

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(RW)) ldFifo (
    .clk       (clk),
    .rst       (rst),
    .pushValid (ld_valid),
    .pushReady (ld_ready),
    .pushData  (ldIn),
    .popEn     (grantLd),
    .headValid (ldHv),
    .headData  (ldHead),
    .count     (ld_count)
  );

`ifdef CDB_FIXED_PRIO_EN
  // The loader may starve while float results keep arriving.
  assign grantFu = fuHv;
  assign grantLd = ldHv && !fuHv;
`else
  logic rrPtr;  // 0 = float side has priority, 1 = loader

  assign grantFu = fuHv && (!ldHv || !rrPtr);
  assign grantLd = ldHv && !grantFu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr <= 1'b0;
    end else if (grantFu) begin
      rrPtr <= 1'b1;
    end else if (grantLd) begin
      rrPtr <= 1'b0;
    end
  end
`endif

  assign selHead = grantLd ? ldHead : fuHead;

  // Payload fields hold their last value on idle cycles; only bus_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_valid <= 1'b0;
      bus_data  <= '0;
      bus_src   <= '0;
      bus_reg   <= '0;
      bus_jeq   <= 1'b0;
      bus_taken <= 1'b0;
      bus_from  <= 1'b0;
    end else if (grantFu || grantLd) begin
      bus_valid <= 1'b1;
      bus_data  <= selHead.data;
      bus_src   <= selHead.src;
      bus_reg   <= selHead.dst;
      bus_jeq   <= selHead.jeq;
      bus_taken <= selHead.jeq & selHead.taken;
      bus_from  <= grantLd;
    end else begin
      bus_valid <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(grantFu && grantLd));
  assert property (@(posedge clk) disable iff (rst) (fuHv || ldHv) |-> (grantFu || grantLd));
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, contention, jeq, lone loader, fixed-priority mode.
module tb_cdb_arbiter;
  localparam int DEPTH = 2;
  localparam int W     = 16;
  localparam int TW    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fu_valid, fu_jeq, fu_taken, ld_valid;
  logic [W-1:0]  fu_data, ld_data;
  logic [TW-1:0] fu_src, fu_reg, ld_src, ld_reg;
  logic          fu_ready, ld_ready;
  logic          bus_valid, bus_jeq, bus_taken, bus_from;
  logic [W-1:0]  bus_data;
  logic [TW-1:0] bus_src, bus_reg;
  logic [CW-1:0] fu_count, ld_count;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.DEPTH(DEPTH), .W(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_data(fu_data), .fu_src(fu_src),
    .fu_reg(fu_reg), .fu_jeq(fu_jeq), .fu_taken(fu_taken),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_src(ld_src), .ld_reg(ld_reg),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_src(bus_src), .bus_reg(bus_reg),
    .bus_jeq(bus_jeq), .bus_taken(bus_taken), .bus_from(bus_from),
    .fu_count(fu_count), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fu_valid = 1'b0; fu_data = '0; fu_src = '0; fu_reg = '0; fu_jeq = 1'b0; fu_taken = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_src = '0; ld_reg = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid got %b want 0", bus_valid); end
    checks++; if (fu_count !== 2'd0) begin errors++; $display("FAIL reset_fu_count got %0d want 0", fu_count); end
    checks++; if (ld_count !== 2'd0) begin errors++; $display("FAIL reset_ld_count got %0d want 0", ld_count); end
    checks++; if (bus_data !== 16'h0 || bus_src !== 4'h0 || bus_reg !== 4'h0 || bus_from !== 1'b0 || bus_jeq !== 1'b0)
      begin errors++; $display("FAIL reset_bus_fields got data %h src %h reg %h from %b jeq %b want all 0", bus_data, bus_src, bus_reg, bus_from, bus_jeq); end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (fu_ready !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got fu %b ld %b want 1 1", fu_ready, ld_ready); end
    // Fill to fu_count=2, ld_count=1: e0 push both, e1 F pops, e2 L pops with L full.
    fu_valid = 1'b1; fu_data = 16'h1111;
    ld_valid = 1'b1; ld_data = 16'h2222;
    tick(); tick(); tick();
    checks++; if (fu_count !== 2'd2 || ld_count !== 2'd1) begin errors++; $display("FAIL midstream_counts got fu %0d ld %0d want 2 1", fu_count, ld_count); end
    checks++; if (bus_valid !== 1'b1 || bus_from !== 1'b1) begin errors++; $display("FAIL midstream_bus got valid %b from %b want 1 1", bus_valid, bus_from); end
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL async_reset_bus_valid got %b want 0", bus_valid); end
    checks++; if (fu_count !== 2'd0 || ld_count !== 2'd0) begin errors++; $display("FAIL async_reset_counts got fu %0d ld %0d want 0 0", fu_count, ld_count); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL stale_after_reset cycle %0d got valid %b want 0", k, bus_valid); end
    end
  endtask

  task automatic test_single();
    do_reset();
    fu_valid = 1'b1; fu_data = 16'h1234; fu_src = 4'd1; fu_reg = 4'd5;
    tick();
    fu_valid = 1'b0;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got valid %b want 0", bus_valid); end
    checks++; if (fu_count !== 2'd1) begin errors++; $display("FAIL single_count got %0d want 1", fu_count); end
    tick();
    checks++; if (bus_valid !== 1'b1 || bus_data !== 16'h1234 || bus_src !== 4'd1 || bus_reg !== 4'd5 || bus_from !== 1'b0 || bus_jeq !== 1'b0)
      begin errors++; $display("FAIL single_bcast got v %b d %h s %0d r %0d f %b j %b want 1 1234 1 5 0 0", bus_valid, bus_data, bus_src, bus_reg, bus_from, bus_jeq); end
    tick();
    checks++; if (bus_valid !== 1'b0 || bus_data !== 16'h1234) begin errors++; $display("FAIL single_idle_hold got v %b d %h want 0 1234", bus_valid, bus_data); end
  endtask

  task automatic test_contention();
    int fi = 0;
    int li = 0;
    logic accF, accL, sawFuFull, sawLdFull, sawFuNr, sawLdNr;
    logic [W-1:0] expData;
    logic expFrom;
    sawFuFull = 0; sawLdFull = 0; sawFuNr = 0; sawLdNr = 0;
    do_reset();
    fu_valid = 1'b1; ld_valid = 1'b1;
    fu_data = 16'hA000; ld_data = 16'hB000;
    for (int k = 0; k < 12; k++) begin
      accF = fu_ready; accL = ld_ready;
      tick();
      if (accF) fi++;
      if (accL) li++;
      fu_data = 16'hA000 + 16'(fi);
      ld_data = 16'hB000 + 16'(li);
      if (fu_count == 2'd2) sawFuFull = 1;
      if (ld_count == 2'd2) sawLdFull = 1;
      if (!fu_ready) sawFuNr = 1;
      if (!ld_ready) sawLdNr = 1;
      if (k >= 1) begin
        expFrom = (k % 2 == 0);
        expData = expFrom ? 16'hB000 + 16'((k - 2) / 2) : 16'hA000 + 16'((k - 1) / 2);
        checks++; if (bus_valid !== 1'b1 || bus_from !== expFrom || bus_data !== expData)
          begin errors++; $display("FAIL contention edge %0d got v %b from %b d %h want 1 %b %h", k, bus_valid, bus_from, bus_data, expFrom, expData); end
      end
    end
    checks++; if (!(sawFuFull && sawLdFull)) begin errors++; $display("FAIL contention_full got fu %b ld %b want 1 1", sawFuFull, sawLdFull); end
    checks++; if (!(sawFuNr && sawLdNr)) begin errors++; $display("FAIL contention_ready_drop got fu %b ld %b want 1 1", sawFuNr, sawLdNr); end
  endtask

  task automatic test_jeq();
    do_reset();
    fu_valid = 1'b1; fu_jeq = 1'b1; fu_taken = 1'b1; fu_data = 16'h0003; fu_src = 4'd2; fu_reg = 4'd7;
    tick();
    fu_valid = 1'b0;
    ld_valid = 1'b1; ld_data = 16'h0055; ld_src = 4'd3; ld_reg = 4'd4;
    tick();
    ld_valid = 1'b0;
    checks++; if (bus_valid !== 1'b1 || bus_jeq !== 1'b1 || bus_taken !== 1'b1 || bus_data !== 16'h0003 || bus_from !== 1'b0)
      begin errors++; $display("FAIL jeq_bcast got v %b j %b t %b d %h f %b want 1 1 1 0003 0", bus_valid, bus_jeq, bus_taken, bus_data, bus_from); end
    tick();
    checks++; if (bus_valid !== 1'b1 || bus_from !== 1'b1 || bus_jeq !== 1'b0 || bus_taken !== 1'b0 || bus_data !== 16'h0055)
      begin errors++; $display("FAIL jeq_then_load got v %b f %b j %b t %b d %h want 1 1 0 0 0055", bus_valid, bus_from, bus_jeq, bus_taken, bus_data); end
    idle_inputs();
  endtask

  task automatic test_lone_loader();
    do_reset();
    ld_valid = 1'b1; ld_src = 4'd6; ld_reg = 4'd9;
    for (int i = 0; i < 3; i++) begin
      ld_data = 16'hC000 + 16'(i);
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL lone_ready push %0d got %b want 1", i, ld_ready); end
      tick();
      if (i > 0) begin
        checks++; if (bus_valid !== 1'b1 || bus_from !== 1'b1 || bus_data !== 16'hC000 + 16'(i - 1))
          begin errors++; $display("FAIL lone_bcast %0d got v %b f %b d %h want 1 1 %h", i - 1, bus_valid, bus_from, bus_data, 16'hC000 + 16'(i - 1)); end
      end
    end
    ld_valid = 1'b0;
    tick();
    checks++; if (bus_valid !== 1'b1 || bus_data !== 16'hC002 || bus_src !== 4'd6 || bus_reg !== 4'd9)
      begin errors++; $display("FAIL lone_last got v %b d %h s %0d r %0d want 1 C002 6 9", bus_valid, bus_data, bus_src, bus_reg); end
    tick();
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL lone_idle got %b want 0", bus_valid); end
  endtask

  task automatic test_fixed_prio();
    int fi = 0;
    int li = 0;
    logic accF, accL;
    logic [CW-1:0] prevFc;
    logic [W-1:0] expData;
    logic expFrom;
    do_reset();
    fu_valid = 1'b1; ld_valid = 1'b1;
    fu_data = 16'hA000; ld_data = 16'hB000;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) fu_valid = 1'b0;
      accF = fu_valid && fu_ready; accL = ld_valid && ld_ready;
      prevFc = fu_count;
      tick();
      if (accF) fi++;
      if (accL) li++;
      fu_data = 16'hA000 + 16'(fi);
      ld_data = 16'hB000 + 16'(li);
      if (k >= 1) begin
        expFrom = (k >= 5);
        expData = expFrom ? 16'hB000 + 16'(k - 5) : 16'hA000 + 16'(k - 1);
        checks++; if (bus_valid !== 1'b1 || bus_from !== expFrom || bus_data !== expData)
          begin errors++; $display("FAIL fixed edge %0d got v %b from %b d %h want 1 %b %h", k, bus_valid, bus_from, bus_data, expFrom, expData); end
        if (expFrom) begin
          checks++; if (prevFc !== 2'd0) begin errors++; $display("FAIL fixed_load_gate edge %0d got fu_count %0d want 0", k, prevFc); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef CDB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_contention();
`endif
    test_jeq();
    test_lone_loader();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
